// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit-count helper
// for the binary-to-BCD converter.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;
   localparam logic [3:0] ADD3_VAL = 4'd3;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   function automatic int bcd_digits(input int bin_w);
      return (bin_w + 2) / 3;
   endfunction

endpackage

// File: rtl/binary_to_bcd_if.sv
// Request/result bundle between a binary producer and
// the BCD converter.
interface binary_to_bcd_if #(
   parameter int BIN_W = 4
);
   import bcd_pkg::*;

   localparam int DIGITS = bcd_digits(BIN_W);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;

   logic             start;
   logic [BIN_W-1:0] binary;
   logic             busy;
   logic             done;
   logic [BCD_W-1:0] bcd_out;

   modport master (
      output start,
      output binary,
      input  busy,
      input  done,
      input  bcd_out
   );

   modport slave (
      input  start,
      input  binary,
      output busy,
      output done,
      output bcd_out
   );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more
// gets +3 so the following left shift carries into the next digit.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   always_comb begin
      adjusted = digit;
      if (digit >= ADD3_THRESH) begin
         adjusted = digit + ADD3_VAL;
      end
   end

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential shift-and-add-3 converter: one bit per cycle,
// result registered and announced with a one-cycle done pulse.
module binary_to_bcd
   import bcd_pkg::*;
#(
   parameter int BIN_W = 4
) (
   input logic clk,
   input logic rst,
   binary_to_bcd_if.slave bus
);

   localparam int DIGITS = bcd_digits(BIN_W);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int CAT_W = BCD_W + BIN_W;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [BIN_W-1:0] sreg;
   logic [BCD_W-1:0] scratch;
   logic [BCD_W-1:0] adj;
   logic [BCD_W-1:0] bcd_q;
   logic             busy_q;
   logic             done_q;
   logic [CAT_W-1:0] shifted;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .adjusted (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // Correct every digit first, then move the next binary bit in.
   assign shifted = {adj, sreg} << 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         sreg    <= '0;
         scratch <= '0;
         bcd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  sreg    <= bus.binary;
                  scratch <= '0;
                  cnt     <= CNT_W'(BIN_W);
                  busy_q  <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= shifted[CAT_W-1:BIN_W];
               sreg    <= shifted[BIN_W-1:0];
               cnt     <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               bcd_q  <= scratch;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench for binary_to_bcd at 4-bit and 8-bit widths.
module tb_binary_to_bcd;
   import bcd_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   binary_to_bcd_if #(.BIN_W(4)) b4 ();
   binary_to_bcd_if #(.BIN_W(8)) b8 ();

   binary_to_bcd #(.BIN_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (b4)
   );

   binary_to_bcd #(.BIN_W(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (b8)
   );

   int errors = 0;
   int checks = 0;
   int dones4 = 0;
   int dones8 = 0;
   logic [7:0]  q4[$];
   logic [11:0] q8[$];

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[3:0]  = 4'(v % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[11:8] = 4'((v / 100) % 10);
      return r;
   endfunction

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      logic [7:0]  e4;
      logic [11:0] e8;
      if (b4.done === 1'b1) begin
         dones4++;
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL done4_unexpected: bcd=%h, required no done",
                     b4.bcd_out);
         end else begin
            e4 = q4.pop_front();
            if (b4.bcd_out !== e4) begin
               errors++;
               $display("FAIL bcd4: got %h, required %h", b4.bcd_out, e4);
            end
         end
      end
      if (b8.done === 1'b1) begin
         dones8++;
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("FAIL done8_unexpected: bcd=%h, required no done",
                     b8.bcd_out);
         end else begin
            e8 = q8.pop_front();
            if (b8.bcd_out !== e8) begin
               errors++;
               $display("FAIL bcd8: got %h, required %h", b8.bcd_out, e8);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic conv4(input int v);
      logic [11:0] e;
      int k;
      bit seen;
      e = to_bcd(v);
      q4.push_back(e[7:0]);
      b4.start = 1'b1;
      b4.binary = 4'(v);
      k = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         k++;
         if (k == 1) b4.start = 1'b0;
         if (b4.done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL conv4_timeout: no done for %0d, required done", v);
      end else if (k != 6) begin
         errors++;
         $display("FAIL conv4_latency: got %0d, required 6", k);
      end
   endtask

   task automatic conv8(input int v);
      int k;
      bit seen;
      q8.push_back(to_bcd(v));
      b8.start = 1'b1;
      b8.binary = 8'(v);
      k = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         k++;
         if (k == 1) b8.start = 1'b0;
         if (b8.done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL conv8_timeout: no done for %0d, required done", v);
      end else if (k != 10) begin
         errors++;
         $display("FAIL conv8_latency: got %0d, required 10", k);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      b4.start = 1'b0;
      b4.binary = '0;
      b8.start = 1'b0;
      b8.binary = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({b4.busy, b4.done, b4.bcd_out} !== 10'd0) begin
         errors++;
         $display("FAIL reset4: got busy=%b done=%b bcd=%h, required 0",
                  b4.busy, b4.done, b4.bcd_out);
      end
      checks++;
      if ({b8.busy, b8.done, b8.bcd_out} !== 14'd0) begin
         errors++;
         $display("FAIL reset8: got busy=%b done=%b bcd=%h, required 0",
                  b8.busy, b8.done, b8.bcd_out);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_sweep;
      logic [7:0] want;
      for (int v = 0; v < 16; v++) begin
         conv4(v);
         want = 8'h00;
         case (v)
            9:  want = 8'h09;
            10: want = 8'h10;
            15: want = 8'h15;
            default: want = 8'h00;
         endcase
         if (v == 0 || v == 9 || v == 10 || v == 15) begin
            checks++;
            if (b4.bcd_out !== want) begin
               errors++;
               $display("FAIL sweep_%0d: got %h, required %h",
                        v, b4.bcd_out, want);
            end
         end
      end
   endtask

   task automatic test_latency;
      @(negedge clk);
      q4.push_back(8'h07);
      b4.start = 1'b1;
      b4.binary = 4'd7;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) b4.start = 1'b0;
         checks++;
         if (k <= 5) begin
            if (b4.busy !== 1'b1 || b4.done !== 1'b0) begin
               errors++;
               $display("FAIL lat_busy_k%0d: busy=%b done=%b, required 1 0",
                        k, b4.busy, b4.done);
            end
         end else if (k == 6) begin
            if (b4.busy !== 1'b0 || b4.done !== 1'b1 ||
                b4.bcd_out !== 8'h07) begin
               errors++;
               $display("FAIL lat_done: busy=%b done=%b bcd=%h, required 0 1 07",
                        b4.busy, b4.done, b4.bcd_out);
            end
         end else begin
            if (b4.done !== 1'b0) begin
               errors++;
               $display("FAIL lat_pulse: done=%b, required 0", b4.done);
            end
         end
      end
   endtask

   task automatic test_start_while_busy;
      int d0;
      int k;
      d0 = dones4;
      q4.push_back(8'h12);
      b4.start = 1'b1;
      b4.binary = 4'd12;
      k = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         k++;
         if (k == 1) b4.start = 1'b0;
         if (k == 2) begin
            b4.start = 1'b1;
            b4.binary = 4'd3;
         end
         if (k == 3) b4.start = 1'b0;
      end
      checks++;
      if (dones4 - d0 != 1) begin
         errors++;
         $display("FAIL busy_ignore: got %0d dones, required 1", dones4 - d0);
      end
      conv4(3);
      checks++;
      if (b4.bcd_out !== 8'h03) begin
         errors++;
         $display("FAIL after_busy: got %h, required 03", b4.bcd_out);
      end
   endtask

   task automatic test_reset_mid;
      int d0;
      @(negedge clk);
      conv4(14);
      @(negedge clk);
      b4.start = 1'b1;
      b4.binary = 4'd13;
      @(negedge clk);
      b4.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({b4.busy, b4.done, b4.bcd_out} !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b bcd=%h, required 0",
                  b4.busy, b4.done, b4.bcd_out);
      end
      d0 = dones4;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (dones4 != d0) begin
         errors++;
         $display("FAIL abort_done: got %0d dones, required 0", dones4 - d0);
      end
      conv4(5);
      checks++;
      if (b4.bcd_out !== 8'h05) begin
         errors++;
         $display("FAIL after_reset: got %h, required 05", b4.bcd_out);
      end
   endtask

   task automatic test_width8;
      @(negedge clk);
      conv8(255);
      checks++;
      if (b8.bcd_out !== 12'h255) begin
         errors++;
         $display("FAIL w8_255: got %h, required 255", b8.bcd_out);
      end
      conv8(100);
      checks++;
      if (b8.bcd_out !== 12'h100) begin
         errors++;
         $display("FAIL w8_100: got %h, required 100", b8.bcd_out);
      end
      conv8(37);
   endtask

   task automatic test_hold;
      @(negedge clk);
      conv4(11);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         b4.binary = 4'($urandom_range(0, 15));
         checks++;
         if (b4.bcd_out !== 8'h11 || b4.done !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: bcd=%h done=%b, required 11 0",
                     i, b4.bcd_out, b4.done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_latency();
      test_start_while_busy();
      test_reset_mid();
      test_width8();
      test_hold();
      repeat (3) @(negedge clk);
      checks++;
      if (q4.size() != 0 || q8.size() != 0) begin
         errors++;
         $display("FAIL pending: got %0d/%0d results outstanding, required 0/0",
                  q4.size(), q8.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
